// File: rtl/quad_enc_pkg.sv
// Shared register map, CTRL/STATUS bit positions and decode types for the
// quadrature encoder reader.
package quad_enc_pkg;

    localparam logic [2:0] REG_POSITION = 3'd0;
    localparam logic [2:0] REG_CTRL     = 3'd1;
    localparam logic [2:0] REG_FILT_LEN = 3'd2;
    localparam logic [2:0] REG_VEL_WIN  = 3'd3;
    localparam logic [2:0] REG_VELOCITY = 3'd4;
    localparam logic [2:0] REG_IDXPOS   = 3'd5;
    localparam logic [2:0] REG_STATUS   = 3'd6;
    localparam logic [2:0] REG_ERRCNT   = 3'd7;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_CLR_IDX = 1;
    localparam int CTRL_INVERT  = 2;

    localparam int STAT_DIR = 0;
    localparam int STAT_ERR = 1;
    localparam int STAT_IDX = 2;

    typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ILL} step_e;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/quad_enc_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output follows
// the synchronized input only after it has disagreed for filt_len+1 cycles.
module quad_enc_filter #(
    parameter int FILT_W = 16
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset_n,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              din,
    output logic              dout
);

    logic [1:0]        sync;
    logic [FILT_W-1:0] cnt;

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            // >= keeps a shortened filt_len from stranding a count above it
            if (sync[1] != dout) begin
                if (cnt >= filt_len) begin
                    dout <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quadrature_encoder_reader.sv
// x4 quadrature decoder with index capture, velocity window and an
// Avalon-MM register slave.
module quadrature_encoder_reader
    import quad_enc_pkg::*;
#(
    parameter int FILT_W = 16
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    input  logic        enc_A,
    input  logic        enc_B,
    input  logic        enc_I,
    output logic        enc_dir,
    output logic        enc_err
);

    logic [2:0]        enc_raw, filt, filt_q;   // {I, B, A}
    logic [FILT_W-1:0] filt_len;
    logic [2:0]        ctrl;
    logic [31:0]       position, vel_win, velocity, idxpos, errcnt;
    logic [31:0]       win_cnt, win_acc;
    logic              st_dir, st_err, st_idx;
    logic [31:0]       rd_mux, wr_merged, delta;
    logic              idx_rise;
    step_e             step;

    assign enc_raw = {enc_I, enc_B, enc_A};

    for (genvar g = 0; g < 3; g++) begin : g_filt
        quad_enc_filter #(.FILT_W(FILT_W)) u_filt (
            .csi_MCLK_clk    (csi_MCLK_clk),
            .rsi_MRST_reset_n(rsi_MRST_reset_n),
            .filt_len        (filt_len),
            .din             (enc_raw[g]),
            .dout            (filt[g])
        );
    end

    // Forward Gray order 00->01->11->10 means up == prev_A ^ cur_B.
    always_comb begin
        step = STEP_NONE;
        if (ctrl[CTRL_ENABLE] && filt[1:0] != filt_q[1:0]) begin
            if (filt[0] != filt_q[0] && filt[1] != filt_q[1])
                step = STEP_ILL;
            else if (filt_q[0] ^ filt[1] ^ ctrl[CTRL_INVERT])
                step = STEP_UP;
            else
                step = STEP_DN;
        end
    end

    assign idx_rise = filt[2] & ~filt_q[2];
    assign delta    = (step == STEP_UP) ? 32'd1 :
                      (step == STEP_DN) ? 32'hFFFF_FFFF : 32'd0;

    always_comb begin
        rd_mux = '0;
        case (avs_ctrl_address)
            REG_POSITION: rd_mux = position;
            REG_CTRL:     rd_mux[2:0] = ctrl;
            REG_FILT_LEN: rd_mux = 32'(filt_len);
            REG_VEL_WIN:  rd_mux = vel_win;
            REG_VELOCITY: rd_mux = velocity;
            REG_IDXPOS:   rd_mux = idxpos;
            REG_STATUS: begin
                rd_mux[STAT_DIR] = st_dir;
                rd_mux[STAT_ERR] = st_err;
                rd_mux[STAT_IDX] = st_idx;
            end
            REG_ERRCNT:   rd_mux = errcnt;
            default:      rd_mux = '0;
        endcase
    end

    assign wr_merged = be_merge(rd_mux, avs_ctrl_writedata, avs_ctrl_byteenable);

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            filt_q            <= '0;
            filt_len          <= '0;
            ctrl              <= '0;
            position          <= '0;
            vel_win           <= '0;
            velocity          <= '0;
            idxpos            <= '0;
            errcnt            <= '0;
            win_cnt           <= '0;
            win_acc           <= '0;
            st_dir            <= 1'b0;
            st_err            <= 1'b0;
            st_idx            <= 1'b0;
            avs_ctrl_readdata <= '0;
        end else begin
            filt_q <= filt;

            if (avs_ctrl_write && avs_ctrl_address == REG_POSITION)
                position <= wr_merged;
            else if (idx_rise && ctrl[CTRL_CLR_IDX])
                position <= '0;
            else
                position <= position + delta;

            if (idx_rise) idxpos <= position;

            if (step == STEP_UP) st_dir <= 1'b1;
            else if (step == STEP_DN) st_dir <= 1'b0;

            // Set events beat a same-cycle W1C.
            if (step == STEP_ILL) st_err <= 1'b1;
            else if (avs_ctrl_write && avs_ctrl_address == REG_STATUS &&
                     avs_ctrl_writedata[STAT_ERR]) st_err <= 1'b0;

            if (idx_rise) st_idx <= 1'b1;
            else if (avs_ctrl_write && avs_ctrl_address == REG_STATUS &&
                     avs_ctrl_writedata[STAT_IDX]) st_idx <= 1'b0;

            if (avs_ctrl_write && avs_ctrl_address == REG_ERRCNT)
                errcnt <= '0;
            else if (step == STEP_ILL && errcnt != 32'hFFFF_FFFF)
                errcnt <= errcnt + 32'd1;

            if (avs_ctrl_write && avs_ctrl_address == REG_CTRL)
                ctrl <= avs_ctrl_writedata[2:0];
            if (avs_ctrl_write && avs_ctrl_address == REG_FILT_LEN)
                filt_len <= wr_merged[FILT_W-1:0];
            if (avs_ctrl_write && avs_ctrl_address == REG_VEL_WIN)
                vel_win <= wr_merged;

            if (vel_win == 32'd0) begin
                velocity <= '0;
                win_cnt  <= '0;
                win_acc  <= '0;
            end else if (win_cnt >= vel_win - 32'd1) begin
                velocity <= win_acc + delta;
                win_cnt  <= '0;
                win_acc  <= '0;
            end else begin
                win_cnt <= win_cnt + 32'd1;
                win_acc <= win_acc + delta;
            end

            if (avs_ctrl_read && !avs_ctrl_write)
                avs_ctrl_readdata <= rd_mux;
        end
    end

    assign avs_ctrl_waitrequest = 1'b0;
    assign enc_dir              = st_dir;
    assign enc_err              = st_err;

endmodule
